// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-path types and default addresses for the MIPS mono-cycle core
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } fetch_state_t;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR,
    SEL_EXC
  } pc_sel_t;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_1000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0180;

  // J-type target: region bits come from the delay-slot address, not from pc
  function automatic logic [31:0] jump_target(input logic [3:0]  region,
                                              input logic [25:0] index);
    return {region, index, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-PC priority mux with jump-target formation and misalign check
// Optional: PC_MISALIGN_TRAP_EN turns misaligned jr/branch targets into an exception redirect.
module pc_next_sel
  import mips_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic [31:0] pc,
  input  logic        exception,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        branch_taken,
  input  logic [31:0] pc_branch,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  pc_sel_t     sel;
  logic [31:0] target;
  logic        raw_mis;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    sel = SEL_SEQ;
    if (exception)         sel = SEL_EXC;
    else if (jr)           sel = SEL_JR;
    else if (jump)         sel = SEL_J;
    else if (branch_taken) sel = SEL_BR;
  end

  always_comb begin
    target = pc_plus4;
    case (sel)
      SEL_EXC: target = EXC_VECTOR;
      SEL_JR:  target = jr_target;
      SEL_J:   target = jump_target(pc_plus4[31:28], jump_index);
      SEL_BR:  target = pc_branch;
      default: target = pc_plus4;
    endcase
  end

  // only register/adder-supplied targets can arrive unaligned
  assign raw_mis = ((sel == SEL_JR) || (sel == SEL_BR)) && (target[1:0] != 2'b00);

`ifdef PC_MISALIGN_TRAP_EN
  assign misaligned = raw_mis;
  assign next_pc    = raw_mis ? EXC_VECTOR : target;
`else
  assign misaligned = 1'b0;
  assign next_pc    = raw_mis ? {target[31:2], 2'b00} : target;
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register, fetch FSM and accepted-fetch counter for the MIPS mono-cycle core
// Optional: PC_MISALIGN_TRAP_EN (handled in pc_next_sel) traps misaligned jr/branch targets.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = mips_pkg::DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = mips_pkg::DEF_EXC_VECTOR,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_ready,
  input  logic             branch_taken,
  input  logic [31:0]      pc_branch,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  input  logic             jr,
  input  logic [31:0]      jr_target,
  input  logic             exception,
  input  logic             halt,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             if_valid,
  output logic [CNT_W-1:0] fetch_count,
  output logic             misaligned
);

  import mips_pkg::*;

  fetch_state_t state;
  logic         exc_pend;
  logic         exc_req;
  logic         fire;
  logic [31:0]  next_pc;
  logic         sel_mis;

  assign fire    = if_valid & if_ready;
  assign exc_req = exception | exc_pend;

  pc_next_sel #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_sel (
    .pc           (pc),
    .exception    (exc_req),
    .jr           (jr),
    .jr_target    (jr_target),
    .jump         (jump),
    .jump_index   (jump_index),
    .branch_taken (branch_taken),
    .pc_branch    (pc_branch),
    .pc_plus4     (pc_plus4),
    .next_pc      (next_pc),
    .misaligned   (sel_mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      fetch_count <= '0;
      misaligned  <= 1'b0;
      exc_pend    <= 1'b0;
    end else begin
      misaligned <= fire & sel_mis;
      if (fire) fetch_count <= fetch_count + {{(CNT_W-1){1'b0}}, 1'b1};

      case (state)
        BOOT: begin
          // a trap arriving before the first fetch is held until RUN
          state    <= RUN;
          if_valid <= 1'b1;
          if (exception) exc_pend <= 1'b1;
        end
        RUN, HALTED: begin
          if (exc_req) begin
            pc       <= EXC_VECTOR;
            state    <= RUN;
            if_valid <= 1'b1;
            exc_pend <= 1'b0;
          end else if (fire) begin
            pc <= next_pc;
            if (halt) begin
              state    <= HALTED;
              if_valid <= 1'b0;
            end
          end
        end
        default: begin
          state    <= BOOT;
          if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and next-PC selector for the MIPS mono-cycle core.
- Sits directly downstream of the branch-target adder: consumes its absolute branch target (PC+4+signext(imm)<<2) plus jump/jr/exception controls.
- Drives the PC into instruction memory, and back into the adder, through a valid/ready fetch handshake with stall, halt and pending-redirect handling.

Parameters:
- RESET_PC, 32'h0000_1000, PC value loaded on reset.
- EXC_VECTOR, 32'h8000_0180, exception entry address.
- CNT_W, 32, width of the accepted-fetch counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_ready  in  1  consumer accepts the current PC this cycle.
- branch_taken  in  1  conditional branch resolved taken for the current PC.
- pc_branch  in  32  absolute branch target from the branch-target adder.
- jump  in  1  J/JAL for the current PC.
- jump_index  in  26  instr[25:0].
- jr  in  1  JR/JALR for the current PC.
- jr_target  in  32  register-file value.
- exception  in  1  asynchronous-to-fetch trap request.
- halt  in  1  stop fetching after the current PC is accepted.
- pc  out  32  current PC.
- pc_plus4  out  32  pc+4, mod 2^32.
- if_valid  out  1  pc is a valid fetch address.
- fetch_count  out  CNT_W  number of accepted fetches.
- misaligned  out  1  one-cycle pulse: selected target had bits[1:0]≠0.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=BOOT, if_valid=0, fetch_count=0, misaligned=0.
  - Release is sampled on clk; no glitch on outputs.
- States:
  - BOOT: if_valid=0 for exactly one cycle, then →RUN. pc unchanged.
  - RUN: if_valid=1. fire = if_valid & if_ready.
    - On fire: pc←next_pc, fetch_count+1 (wraps to 0 at max).
    - If halt&fire: →HALTED and pc←next_pc.
    - No fire: pc, state hold. All redirect inputs are ignored (sampled only on fire).
  - HALTED: if_valid=0, pc holds. Leave only via exception or reset.
- next_pc priority, evaluated only on fire, highest first:
  - exception → EXC_VECTOR.
  - jr → jr_target.
  - jump → {pc_plus4[31:28], jump_index, 2'b00}.
  - branch_taken → pc_branch.
  - otherwise → pc_plus4.
- Exception:
  - Honoured in any state except BOOT, with or without fire: pc←EXC_VECTOR, state←RUN next cycle.
  - fetch_count increments only if fire that cycle.
  - In BOOT, exception is deferred one cycle and is not lost; it is latched in a pending flag.
- Simultaneous events:
  - exception+halt → exception wins, state RUN.
  - jr+jump+branch → jr.
- Arithmetic: all 32-bit unsigned modulo 2^32. pc=32'hFFFF_FFFC gives pc_plus4=0.
- Latency: next_pc is visible on pc one cycle after the fire edge.
- Reset mid-operation aborts everything, including a pending BOOT exception.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined: a selected jr_target or pc_branch with bits[1:0]≠0:
  - redirects to EXC_VECTOR instead;
  - misaligned pulses for 1 cycle;
  - counts as a fire.
- Undefined:
  - target bits[1:0] forced to 2'b00;
  - misaligned tied 0.

Decomposition:
- Shared package mips_pkg:
  - state enum {BOOT, RUN, HALTED};
  - next-PC select enum {SEL_SEQ, SEL_BR, SEL_J, SEL_JR, SEL_EXC};
  - default RESET_PC/EXC_VECTOR constants.
- One sub-module, pc_next_sel: purely combinational priority mux plus jump-target formation and misalign check.
- The parent holds the FSM, PC register and counter.

Test Plan:
- Reset: rst_n low mid-cycle → pc=0x1000 immediately, if_valid=0. Release → if_valid=0 one cycle, then 1.
- Branch: pc=0x1000, branch_taken=1, pc_branch=0x1014, if_ready=1 → next pc=0x1014, fetch_count=1. With pc_branch=0x0FF4 → pc=0x0FF4.
- Stall: if_ready=0 for 3 cycles with branch_taken=1 → pc holds 0x1000, count unchanged. if_ready=1 → pc=0x1014.
- Priority: pc=0x1000, jump=1, jump_index=26'h0000800, branch_taken=1 → pc=0x2000. Add jr=1, jr_target=0x4000 → pc=0x4000.
- Halt/exception: halt&fire at pc=0x1000 → pc=0x1004, if_valid=0 and holds. exception=1 → pc=0x8000_0180, if_valid=1.
- Wrap/misalign: pc=0xFFFF_FFFC sequential → pc=0x0. jr_target=0x4002:
  - with PC_MISALIGN_TRAP_EN → pc=0x8000_0180, misaligned pulse;
  - without → pc=0x4000.
